liseq: RTL and testbench
========================

LISEQ -- requirements
Module: liseq

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 in_valid  input  1  load-immediate request valid.
REQ-004 in_ready  output  1  block can accept a request.
REQ-005 rd  input  5  destination register index.
REQ-006 imm64  input  64  constant to materialise in rd.
REQ-007 out_valid  output  1  out_instr holds a valid instruction.
REQ-008 out_ready  input  1  consumer accepts out_instr this cycle.
REQ-009 out_instr  output  32  raw RV64I instruction word.
REQ-010 out_last  output  1  out_instr is the final instruction of the sequence.

Function
REQ-011 The block SHALL expand one (rd, imm64) request into a sequence of ADDI/SLLI/ORI instructions that leaves rd == imm64, the encoding inverse of the pipeline's immediate extraction.
REQ-012 Chunks SHALL be C5=imm[63:55] (9b, zero-extended), C4=[54:44], C3=[43:33], C2=[32:22], C1=[21:11], C0=[10:0] (11b each); s = highest index with Ck != 0, or 0 if all are zero.
REQ-013 The sequence SHALL be ADDI rd,x0,Cs, then for k = s-1 down to 0: SLLI rd,rd,11 followed by ORI rd,rd,Ck, giving 1+2s instructions.
REQ-014 Encodings SHALL be: ADDI = {imm12, 5'd0, 3'b000, rd, 7'b0010011}; SLLI = {6'b0, 6'd11, rd, 3'b001, rd, 7'b0010011}; ORI = {1'b0, Ck, rd, 3'b110, rd, 7'b0010011}.
REQ-015 rd == 0 SHALL produce a single ADDI x0,x0,0 (0x00000013) with out_last=1.
REQ-016 FSM states SHALL be IDLE, FIRST, SHIFT and OR: IDLE->FIRST on accept; FIRST->SHIFT or done; SHIFT->OR; OR->SHIFT or done; done returns to IDLE.
REQ-017 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid && in_ready, and rd/imm64 are captured at that edge.
REQ-018 out_valid SHALL assert in the cycle after acceptance (latency 1); the sequence is never emitted combinationally from inputs.
REQ-019 An instruction SHALL transfer on out_valid && out_ready; the next instruction follows in the next cycle, so throughput is 1 instruction per cycle under continuous out_ready.
REQ-020 While out_valid && !out_ready, out_instr, out_last and the FSM state SHALL hold stable.
REQ-021 When the out_last instruction transfers, the FSM SHALL return to IDLE; out_valid=0 and in_ready=1 in the next cycle.
REQ-022 Changes on rd/imm64/in_valid while not in IDLE SHALL be ignored.
REQ-023 When out_valid=0, out_instr and out_last SHALL be 0.

Reset
REQ-024 Reset SHALL force IDLE, in_ready=1, out_valid=0, out_instr=0, out_last=0 and clear captured operands, immediately and regardless of clk.
REQ-025 Reset asserted mid-sequence SHALL abandon the sequence; no further instructions from it are emitted.

Configuration
REQ-026 Macro LISEQ_FASTPATH_EN: when defined, if imm64 equals the sign-extension of imm64[11:0], the sequence SHALL be the single ADDI rd,x0,imm64[11:0] with out_last=1.
REQ-027 Without LISEQ_FASTPATH_EN, every request SHALL use only the chunk sequence of REQ-012 to REQ-013 (for example, imm64=-1 takes 11 instructions).

Verification
REQ-028 rd=10, imm64=5, out_ready=1 -> one beat 0x00500513, out_last=1, in_ready back at 1 on the next cycle.
REQ-029 rd=1, imm64=0x800 -> 0x00100093, 0x00B09093, 0x0000E093 on consecutive cycles, out_last only on the third.
REQ-030 rd=5, imm64=0xFFFF_FFFF_FFFF_FFFF -> with the macro, single beat 0xFFF00293; without it, 11 beats, the first 0x1FF00293 and the last an ORI with 0x7FF.
REQ-031 rd=1, imm64=0x800 with out_ready held 0 for 3 cycles on beat 2 -> out_instr stays at 0x00B09093, and the sequence completes once out_ready=1.
REQ-032 reset pulsed during beat 2 of the 0x800 case -> out_valid=0 and in_ready=1 immediately; after release a new request rd=10, imm64=5 yields 0x00500513.

Source files
------------

// File: rtl/liseq.sv
// Load-immediate sequencer: expands (rd, imm64) into ADDI/SLLI/ORI RV64I words.
// Optional macro LISEQ_FASTPATH_EN emits a single ADDI for 12-bit sign-extendable constants.
module liseq (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  rd,
  input  logic [63:0] imm64,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last
);

  typedef enum logic [1:0] {IDLE, FIRST, SHIFT, OR} state_t;

  localparam logic [6:0] OP_IMM = 7'b0010011;

  state_t      state_q, state_d;
  logic [4:0]  rd_q;
  logic [63:0] imm_q;
  logic [2:0]  k_q, k_d;
  logic        fast_q, fast_d;
  logic [2:0]  top_d;
  logic [10:0] cur;

  // Chunk 5 is only 9 bits wide; the rest are 11-bit slices from the bottom up.
  function automatic logic [10:0] chunk(input logic [63:0] v, input logic [2:0] k);
    case (k)
      3'd5:    chunk = {2'b00, v[63:55]};
      3'd4:    chunk = v[54:44];
      3'd3:    chunk = v[43:33];
      3'd2:    chunk = v[32:22];
      3'd1:    chunk = v[21:11];
      default: chunk = v[10:0];
    endcase
  endfunction

  function automatic logic [2:0] top_chunk(input logic [63:0] v);
    top_chunk = 3'd0;
    for (int unsigned k = 1; k < 6; k++)
      if (chunk(v, 3'(k)) != '0) top_chunk = 3'(k);
  endfunction

  assign top_d = top_chunk(imm64);
  assign cur   = chunk(imm_q, k_q);

`ifdef LISEQ_FASTPATH_EN
  assign fast_d = (imm64 == {{52{imm64[11]}}, imm64[11:0]});
`else
  assign fast_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= '0;
      imm_q   <= '0;
      k_q     <= '0;
      fast_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (in_valid && in_ready) begin
        rd_q   <= rd;
        imm_q  <= imm64;
        fast_q <= fast_d;
      end
    end
  end

  // k_q names the chunk emitted by the current FIRST/OR beat.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_instr = '0;
    out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = FIRST;
          k_d     = top_d;
        end
      end
      FIRST: begin
        out_valid = 1'b1;
        if (rd_q == 5'd0) begin
          out_instr = {25'd0, OP_IMM};
          out_last  = 1'b1;
        end else if (fast_q) begin
          out_instr = {imm_q[11:0], 5'd0, 3'b000, rd_q, OP_IMM};
          out_last  = 1'b1;
        end else begin
          out_instr = {1'b0, cur, 5'd0, 3'b000, rd_q, OP_IMM};
          out_last  = (k_q == 3'd0);
        end
        if (out_ready) begin
          if (out_last) begin
            state_d = IDLE;
          end else begin
            state_d = SHIFT;
            k_d     = k_q - 3'd1;
          end
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        out_instr = {6'b0, 6'd11, rd_q, 3'b001, rd_q, OP_IMM};
        if (out_ready) state_d = OR;
      end
      OR: begin
        out_valid = 1'b1;
        out_instr = {1'b0, cur, rd_q, 3'b110, rd_q, OP_IMM};
        out_last  = (k_q == 3'd0);
        if (out_ready) begin
          if (out_last) begin
            state_d = IDLE;
          end else begin
            state_d = SHIFT;
            k_d     = k_q - 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_liseq.sv
// Self-checking bench for liseq: vector table plus scoreboard of expected beats,
// with hand-written stall and mid-sequence reset sequences.
module tb_liseq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  rd;
  logic [63:0] imm64;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_instr;

  always #5 clk = ~clk;

  liseq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rd(rd), .imm64(imm64), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_last(out_last)
  );

  typedef struct {
    logic [31:0] instr;
    logic        last;
  } beat_t;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] imm;
    int unsigned n;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;

  beat_t       exp_q[$];
  vec_t        vecs[9];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned beat_cnt = 0;
  logic [31:0] first_seen, last_seen;
  bit          rand_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_addi(input logic [4:0] r, input logic [11:0] i);
    return {i, 5'd0, 3'b000, r, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_slli(input logic [4:0] r);
    return {6'b0, 6'd11, r, 3'b001, r, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_ori(input logic [4:0] r, input logic [10:0] c);
    return {1'b0, c, r, 3'b110, r, 7'b0010011};
  endfunction

  task automatic model_push(input logic [4:0] r, input logic [63:0] v);
    logic [10:0] c[6];
    int unsigned s = 0;
    c[5] = {2'b00, v[63:55]};
    c[4] = v[54:44];
    c[3] = v[43:33];
    c[2] = v[32:22];
    c[1] = v[21:11];
    c[0] = v[10:0];
    for (int unsigned k = 0; k < 6; k++) if (c[k] != 11'd0) s = k;
    if (r == 5'd0) begin
      exp_q.push_back('{32'h00000013, 1'b1});
      return;
    end
`ifdef LISEQ_FASTPATH_EN
    if (v == {{52{v[11]}}, v[11:0]}) begin
      exp_q.push_back('{enc_addi(r, v[11:0]), 1'b1});
      return;
    end
`endif
    exp_q.push_back('{enc_addi(r, {1'b0, c[s]}), s == 0});
    for (int unsigned j = 0; j < s; j++) begin
      exp_q.push_back('{enc_slli(r), 1'b0});
      exp_q.push_back('{enc_ori(r, c[s-1-j]), (j == s - 1)});
    end
  endtask

  always @(negedge clk) begin : monitor
    beat_t b;
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h, expected no beat", out_instr);
        end else begin
          b = exp_q.pop_front();
          chk("beat_instr", 64'(out_instr), 64'(b.instr));
          chk("beat_last", 64'(out_last), 64'(b.last));
        end
        if (beat_cnt == 0) first_seen = out_instr;
        last_seen = out_instr;
        beat_cnt++;
      end else if (!out_valid) begin
        chk("idle_outputs_zero", 64'({out_last, out_instr}), 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] r, input logic [63:0] v);
    int unsigned t = 0;
    while (!in_ready && t < 100) begin
      step();
      t++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    model_push(r, v);
    beat_cnt = 0;
    in_valid = 1'b1;
    rd       = r;
    imm64    = v;
    step();
    in_valid = 1'b0;
    rd       = 5'($urandom);
    imm64    = {$urandom, $urandom};
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    chk("busy_in_ready", 64'(in_ready), 64'd0);
  endtask

  task automatic wait_done();
    int unsigned t = 0;
    while ((out_valid || exp_q.size() != 0) && t < 400) begin
      out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
      t++;
    end
    out_ready = 1'b1;
    chk("seq_complete", 64'(exp_q.size()), 64'd0);
    chk("done_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    vecs[0] = '{5'd10, 64'd5, 1, 32'h00500513, 32'h00500513};
    vecs[1] = '{5'd1, 64'h800, 3, 32'h00100093, 32'h0000E093};
`ifdef LISEQ_FASTPATH_EN
    vecs[2] = '{5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1, 32'hFFF00293, 32'hFFF00293};
    vecs[8] = '{5'd12, 64'hFFFF_FFFF_FFFF_F800, 1, 32'h80000613, 32'h80000613};
`else
    vecs[2] = '{5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 11, 32'h1FF00293, 32'h7FF2E293};
    vecs[8] = '{5'd12, 64'hFFFF_FFFF_FFFF_F800, 11, 32'h1FF00613, 32'h00066613};
`endif
    vecs[3] = '{5'd0, 64'h1234, 1, 32'h00000013, 32'h00000013};
    vecs[4] = '{5'd7, 64'd0, 1, 32'h00000393, 32'h00000393};
    vecs[5] = '{5'd31, 64'h8000_0000_0000_0000, 11, 32'h10000F93, 32'h000FEF93};
    vecs[6] = '{5'd3, 64'h7FF, 1, 32'h7FF00193, 32'h7FF00193};
    vecs[7] = '{5'd2, 64'h0000_1000_0000_0000, 9, 32'h00100113, 32'h00016113};

    reset = 1'b1; in_valid = 1'b0; rd = '0; imm64 = '0; out_ready = 1'b1;
    #12;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_instr", 64'(out_instr), 64'd0);
    chk("reset_out_last", 64'(out_last), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    for (int unsigned pass = 0; pass < 2; pass++) begin
      rand_mode = (pass == 1);
      for (int unsigned i = 0; i < 9; i++) begin
        send(vecs[i].rd, vecs[i].imm);
        wait_done();
        chk("vec_beat_count", 64'(beat_cnt), 64'(vecs[i].n));
        chk("vec_first_instr", 64'(first_seen), 64'(vecs[i].first));
        chk("vec_last_instr", 64'(last_seen), 64'(vecs[i].last));
      end
    end
    rand_mode = 1'b0;

    // Back-to-back beats of the 0x800 case under continuous out_ready.
    send(5'd1, 64'h800);
    chk("seq800_b1", 64'({out_last, out_instr}), {31'd0, 1'b0, 32'h00100093});
    step();
    chk("seq800_b2", 64'({out_last, out_instr}), {31'd0, 1'b0, 32'h00B09093});
    step();
    chk("seq800_b3", 64'({out_last, out_instr}), {31'd0, 1'b1, 32'h0000E093});
    step();
    chk("seq800_end_valid", 64'(out_valid), 64'd0);
    chk("seq800_end_ready", 64'(in_ready), 64'd1);

    // Stall on beat 2 with noisy request inputs that must be ignored.
    send(5'd1, 64'h800);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int unsigned c = 0; c < 3; c++) begin
      rd    = 5'($urandom);
      imm64 = {$urandom, $urandom};
      step();
      chk("stall_instr", 64'(out_instr), 64'h00B09093);
      chk("stall_last", 64'(out_last), 64'd0);
      chk("stall_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    wait_done();
    chk("stall_beat_count", 64'(beat_cnt), 64'd3);

    // Asynchronous reset during beat 2 abandons the sequence.
    send(5'd1, 64'h800);
    step();
    #1 reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd1);
    chk("async_rst_instr", 64'(out_instr), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("post_rst_quiet", 64'(out_valid), 64'd0);
    send(5'd10, 64'd5);
    wait_done();
    chk("post_rst_beats", 64'(beat_cnt), 64'd1);
    chk("post_rst_instr", 64'(first_seen), 64'h00500513);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
